// File: rtl/canvas_pkg.sv
// Shared canvas definitions: geometry of the 32x32 one-bit canvas RAM and
// the access-controller state encoding used by the recognizer, display and
// access controller.
package canvas_pkg;

    localparam int CANVAS_ADDR_W = 10;
    localparam int CANVAS_DEPTH  = 1 << CANVAS_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/canvas_clear_seq.sv
// Canvas wipe address sequencer: after a start pulse it walks addr from 0 to
// DEPTH-1, one cell per cycle, holding active for exactly DEPTH cycles. done
// marks the last cell.
module canvas_clear_seq
    import canvas_pkg::*;
#(
    parameter int ADDR_W = CANVAS_ADDR_W,
    parameter int DEPTH  = CANVAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              active,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic              run;
    logic [ADDR_W-1:0] cnt;

    // Address counter: armed by start, wraps back to idle after the last cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST_ADDR) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end
    end

    assign active = run;
    assign addr   = cnt;
    assign done   = run && (cnt == LAST_ADDR);

endmodule

// File: rtl/canvas_access_ctrl.sv
// Canvas RAM port arbiter: shares the single read/write port between the pen
// writer, the recognizer scan and the canvas wipe, and latches the result of
// each recognizer session.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | pen owns the port; end_write starts a scan, clear_req a wipe
//   SCAN  | recognizer owns the port (reads only); pen writes are stalled
//   CLEAR | wipe sequencer writes 0 to every cell, one per cycle
module canvas_access_ctrl
    import canvas_pkg::*;
#(
    parameter int ADDR_W       = CANVAS_ADDR_W,
    parameter int DEPTH        = CANVAS_DEPTH,
    parameter int AUTO_CLEAR   = 1,
    parameter int SCAN_TIMEOUT = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              end_write,
    input  logic              clear_req,
    input  logic              pen_req,
    input  logic [ADDR_W-1:0] pen_addr,
    input  logic              pen_data,
    output logic              pen_ack,
    output logic              rec_start,
    input  logic              rec_re,
    input  logic [ADDR_W-1:0] rec_addr,
    output logic              rec_rdata,
    input  logic              rec_done,
    input  logic [7:0]        rec_char,
    output logic [7:0]        char_out,
    output logic              char_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    input  logic              ram_rdata,
    output logic              busy,
    output logic              scan_err,
    output logic [7:0]        drop_cnt
);

    // Scan watchdog is a down-counter: loaded on scan start, times out at 0,
    // so a scan lasts at most SCAN_TIMEOUT cycles.
    localparam int                TMR_W    = $clog2(SCAN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(SCAN_TIMEOUT - 1);

    ctrl_state_t       state, state_next;
    logic [TMR_W-1:0]  scan_tmr;
    logic              pending_clear;
    logic              scan_go;
    logic              scan_done;
    logic              scan_timeout;
    logic              clr_start;
    logic              clr_active;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;

    assign scan_go = (state == IDLE) && end_write;
    assign busy    = (state != IDLE);

    canvas_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (clr_start),
        .active (clr_active),
        .addr   (clr_addr),
        .done   (clr_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and RAM port mux; pen is gated by rst so every output is 0
    // while reset is held.
    always_comb begin
        state_next   = state;
        pen_ack      = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = 1'b0;
        rec_rdata    = 1'b0;
        clr_start    = 1'b0;
        scan_done    = 1'b0;
        scan_timeout = 1'b0;
        case (state)
            IDLE: begin
                pen_ack = pen_req && !rst;
                if (pen_ack) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = pen_addr;
                    ram_wdata = pen_data;
                end
                // A scan beats a coincident clear; the clear is remembered.
                if (end_write) begin
                    state_next = SCAN;
                end else if (clear_req) begin
                    state_next = CLEAR;
                    clr_start  = 1'b1;
                end
            end
            SCAN: begin
                ram_en    = rec_re;
                ram_addr  = rec_addr;
                rec_rdata = ram_rdata;
                if (rec_done) begin
                    scan_done = 1'b1;
                    if ((AUTO_CLEAR != 0) || pending_clear || clear_req) begin
                        state_next = CLEAR;
                        clr_start  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (scan_tmr == '0) begin
                    scan_timeout = 1'b1;
                    state_next   = IDLE;
                end
            end
            CLEAR: begin
                ram_en   = clr_active;
                ram_we   = clr_active;
                ram_addr = clr_addr;
                if (clr_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scan session bookkeeping: start pulse, result latch, error flag, watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_start  <= 1'b0;
            char_valid <= 1'b0;
            char_out   <= '0;
            scan_err   <= 1'b0;
            scan_tmr   <= '0;
        end else begin
            rec_start  <= scan_go;
            char_valid <= scan_done;
            if (scan_done) begin
                char_out <= rec_char;
            end
            if (scan_go) begin
                scan_err <= 1'b0;
            end else if (scan_timeout) begin
                scan_err <= 1'b1;
            end
            if (scan_go) begin
                scan_tmr <= TMR_LOAD;
            end else if ((state == SCAN) && (scan_tmr != '0)) begin
                scan_tmr <= scan_tmr - 1'b1;
            end
        end
    end

    // Deferred clear request and dropped end_write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_clear <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if ((state == IDLE) && end_write && clear_req) begin
                pending_clear <= 1'b1;
            end else if ((state == SCAN) && clear_req) begin
                pending_clear <= 1'b1;
            end else if ((state == CLEAR) && clr_done) begin
                pending_clear <= 1'b0;
            end
            if ((state != IDLE) && end_write && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_canvas_access_ctrl.sv
// Bench for canvas_access_ctrl: dut0 runs without auto-clear, dut1 with it.
// Both share all stimulus; each has its own RAM model behind ram_rdata.
module tb_canvas_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       end_write = 1'b0;
    logic       clear_req = 1'b0;
    logic       pen_req = 1'b0;
    logic [9:0] pen_addr = '0;
    logic       pen_data = 1'b0;
    logic       rec_re = 1'b0;
    logic [9:0] rec_addr = '0;
    logic       rec_done = 1'b0;
    logic [7:0] rec_char = '0;

    logic       pen_ack0, rec_start0, rec_rdata0, char_valid0, ram_en0, ram_we0, ram_wdata0, busy0, scan_err0;
    logic [9:0] ram_addr0;
    logic [7:0] char_out0, drop_cnt0;
    logic       pen_ack1, rec_start1, rec_rdata1, char_valid1, ram_en1, ram_we1, ram_wdata1, busy1, scan_err1;
    logic [9:0] ram_addr1;
    logic [7:0] char_out1, drop_cnt1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic       mem0 [0:1023];
    logic       mem1 [0:1023];

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] char_q [$];
    int         clr_q  [$];

    always #5 clk = ~clk;

    canvas_access_ctrl #(.AUTO_CLEAR(0)) dut0 (
        .clk(clk), .rst(rst), .end_write(end_write), .clear_req(clear_req),
        .pen_req(pen_req), .pen_addr(pen_addr), .pen_data(pen_data), .pen_ack(pen_ack0),
        .rec_start(rec_start0), .rec_re(rec_re), .rec_addr(rec_addr), .rec_rdata(rec_rdata0),
        .rec_done(rec_done), .rec_char(rec_char), .char_out(char_out0), .char_valid(char_valid0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(rd0), .busy(busy0), .scan_err(scan_err0), .drop_cnt(drop_cnt0)
    );

    canvas_access_ctrl #(.AUTO_CLEAR(1)) dut1 (
        .clk(clk), .rst(rst), .end_write(end_write), .clear_req(clear_req),
        .pen_req(pen_req), .pen_addr(pen_addr), .pen_data(pen_data), .pen_ack(pen_ack1),
        .rec_start(rec_start1), .rec_re(rec_re), .rec_addr(rec_addr), .rec_rdata(rec_rdata1),
        .rec_done(rec_done), .rec_char(rec_char), .char_out(char_out1), .char_valid(char_valid1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(rd1), .busy(busy1), .scan_err(scan_err1), .drop_cnt(drop_cnt1)
    );

    // Synchronous single-port RAM models, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en0) begin
            if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
            else         rd0 <= mem0[ram_addr0];
        end
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
            else         rd1 <= mem1[ram_addr1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic push_clr();
        for (int k = 0; k < 1024; k++) clr_q.push_back(k);
    endtask

    task automatic wait_idle(input int which, input int budget, output int cnt);
        cnt = 0;
        while (((which == 0) ? busy0 : busy1) && cnt < budget) begin
            cnt++;
            next();
            #1;
        end
    endtask

    // Result scoreboard for dut0: every char_valid must match a queued rec_done.
    always @(negedge clk) begin
        #3;
        if (!rst && char_valid0) begin
            if (char_q.size() == 0) chk("char_valid_unexpected", 32'(char_valid0), 32'd0);
            else chk("char_out", 32'(char_out0), 32'(char_q.pop_front()));
        end
    end

    // Wipe scoreboard for dut1: non-pen writes must walk 0..1023 with data 0.
    always @(negedge clk) begin
        #3;
        if (!rst && ram_we1 && !pen_ack1) begin
            if (clr_q.size() == 0) chk("clr_write_unexpected", 32'(ram_we1), 32'd0);
            else begin
                chk("clr_addr", 32'(ram_addr1), 32'(clr_q.pop_front()));
                chk("clr_wdata", 32'(ram_wdata1), 32'd0);
            end
        end
    end

    typedef struct {
        logic       req;
        logic [9:0] addr;
        logic       data;
        logic       re;
        logic [9:0] raddr;
        logic       e_ack;
        logic       e_en;
        logic       e_we;
        logic [9:0] e_addr;
        logic       e_wd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cnt;
        int n;

        for (int k = 0; k < 1024; k++) begin
            mem0[k] = 1'b0;
            mem1[k] = 1'b0;
        end
        vecs[0] = '{1'b1, 10'd5,    1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 1'b1, 10'd5,    1'b1};
        vecs[1] = '{1'b0, 10'd7,    1'b1, 1'b1, 10'd77, 1'b0, 1'b0, 1'b0, 10'd0,    1'b0};
        vecs[2] = '{1'b1, 10'd1023, 1'b0, 1'b1, 10'd77, 1'b1, 1'b1, 1'b1, 10'd1023, 1'b0};
        vecs[3] = '{1'b1, 10'd0,    1'b0, 1'b0, 10'd0,  1'b1, 1'b1, 1'b1, 10'd0,    1'b0};
        vecs[4] = '{1'b0, 10'd0,    1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 10'd0,    1'b0};

        // Reset state.
        next(); #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_rec_start", 32'(rec_start0), 32'd0);
        chk("rst_char_out", 32'(char_out0), 32'd0);
        chk("rst_char_valid", 32'(char_valid0), 32'd0);
        chk("rst_scan_err", 32'(scan_err0), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt0), 32'd0);
        chk("rst_ram_en", 32'(ram_en0), 32'd0);
        chk("rst_pen_ack", 32'(pen_ack0), 32'd0);
        rst = 1'b0;

        // Pen writes in IDLE, recognizer reads ignored outside SCAN.
        for (int i = 0; i < 5; i++) begin
            next();
            pen_req = vecs[i].req; pen_addr = vecs[i].addr; pen_data = vecs[i].data;
            rec_re = vecs[i].re; rec_addr = vecs[i].raddr;
            #1;
            chk("vec_pen_ack", 32'(pen_ack0), 32'(vecs[i].e_ack));
            chk("vec_ram_en", 32'(ram_en0), 32'(vecs[i].e_en));
            chk("vec_ram_we", 32'(ram_we0), 32'(vecs[i].e_we));
            chk("vec_ram_addr", 32'(ram_addr0), 32'(vecs[i].e_addr));
            chk("vec_ram_wdata", 32'(ram_wdata0), 32'(vecs[i].e_wd));
            chk("vec_pen_ack1", 32'(pen_ack1), 32'(vecs[i].e_ack));
            chk("vec_ram_addr1", 32'(ram_addr1), 32'(vecs[i].e_addr));
            chk("vec_rec_rdata_idle", 32'(rec_rdata0), 32'd0);
        end
        rec_re = 1'b0; rec_addr = '0;

        // Full scan without auto-clear on dut0; with auto-clear on dut1.
        next();
        end_write = 1'b1; pen_req = 1'b1; pen_addr = 10'd9; pen_data = 1'b0;
        #1;
        chk("scan_entry_pen_ack", 32'(pen_ack0), 32'd1);
        chk("scan_entry_ram_addr", 32'(ram_addr0), 32'd9);
        next(); end_write = 1'b0; #1;
        chk("rec_start_pulse", 32'(rec_start0), 32'd1);
        chk("scan_busy", 32'(busy0), 32'd1);
        chk("scan_pen_stall", 32'(pen_ack0), 32'd0);
        for (int i = 0; i < 1023; i++) begin
            next(); rec_re = 1'b1; rec_addr = 10'(i); #1;
            if (i == 0) chk("rec_start_one_cycle", 32'(rec_start0), 32'd0);
            chk("scan_ram_addr", 32'(ram_addr0), 32'(i));
            chk("scan_ram_en", 32'(ram_en0), 32'd1);
            chk("scan_ram_we", 32'(ram_we0), 32'd0);
            chk("scan_pen_ack", 32'(pen_ack0), 32'd0);
            if (i > 0) chk("scan_rec_rdata", 32'(rec_rdata0), ((i - 1) == 5) ? 32'd1 : 32'd0);
        end
        next(); rec_re = 1'b0; rec_done = 1'b1; rec_char = 8'd65;
        char_q.push_back(8'd65); push_clr();
        #1;
        next(); rec_done = 1'b0; #1;
        chk("post_scan_idle", 32'(busy0), 32'd0);
        chk("stalled_pen_acked", 32'(pen_ack0), 32'd1);
        chk("auto_clear_busy1", 32'(busy1), 32'd1);
        chk("auto_clear_pen_ack1", 32'(pen_ack1), 32'd0);
        next(); pen_req = 1'b0; #1;
        wait_idle(1, 1100, cnt);
        chk("auto_clear_cycles", 32'(cnt + 1), 32'd1024);
        chk("auto_clear_queue_drained", 32'(clr_q.size()), 32'd0);

        // clear_req during SCAN, end_write during CLEAR.
        next(); end_write = 1'b1; #1;
        next(); end_write = 1'b0; #1;
        chk("t4_rec_start", 32'(rec_start0), 32'd1);
        next(); clear_req = 1'b1; rec_re = 1'b1; rec_addr = 10'd3; #1;
        next(); clear_req = 1'b0; rec_re = 1'b0; rec_done = 1'b1; rec_char = 8'd66;
        char_q.push_back(8'd66); push_clr();
        #1;
        next(); rec_done = 1'b0; #1;
        chk("pending_clear_busy", 32'(busy0), 32'd1);
        chk("pending_clear_we", 32'(ram_we0), 32'd1);
        chk("pending_clear_addr0", 32'(ram_addr0), 32'd0);
        chk("pending_clear_wdata", 32'(ram_wdata0), 32'd0);
        next(); end_write = 1'b1; clear_req = 1'b1; #1;
        next(); end_write = 1'b0; clear_req = 1'b0; #1;
        chk("drop_cnt", 32'(drop_cnt0), 32'd1);
        chk("drop_cnt1", 32'(drop_cnt1), 32'd1);
        chk("drop_no_rec_start", 32'(rec_start0), 32'd0);
        chk("clear_addr2", 32'(ram_addr0), 32'd2);
        wait_idle(0, 1100, cnt);
        chk("pending_clear_cycles", 32'(cnt + 2), 32'd1024);
        // pending_clear must be gone: next scan on dut0 ends in IDLE.
        next(); end_write = 1'b1; #1;
        next(); end_write = 1'b0; #1;
        next(); rec_done = 1'b1; rec_char = 8'd67;
        char_q.push_back(8'd67); push_clr();
        #1;
        next(); rec_done = 1'b0; #1;
        chk("pending_cleared_idle", 32'(busy0), 32'd0);
        wait_idle(1, 1100, cnt);

        // Scan timeout: recognizer never finishes.
        next(); end_write = 1'b1; #1;
        next(); end_write = 1'b0; #1;
        cnt = 0;
        while (busy0 && cnt < 2100) begin
            cnt++;
            next(); rec_re = 1'b1; rec_addr = 10'($urandom_range(0, 1023)); #1;
        end
        rec_re = 1'b0;
        chk("timeout_cycles", 32'(cnt), 32'd2047);
        chk("timeout_scan_err", 32'(scan_err0), 32'd1);
        chk("timeout_char_kept", 32'(char_out0), 32'd67);
        chk("timeout_busy1", 32'(busy1), 32'd0);
        next(); end_write = 1'b1; #1;
        chk("scan_err_held", 32'(scan_err0), 32'd1);
        next(); end_write = 1'b0; #1;
        chk("scan_err_cleared", 32'(scan_err0), 32'd0);
        chk("t5_rec_start", 32'(rec_start0), 32'd1);
        next(); rec_done = 1'b1; rec_char = 8'd68;
        char_q.push_back(8'd68); push_clr();
        #1;
        next(); rec_done = 1'b0; #1;
        chk("t5_idle", 32'(busy0), 32'd0);
        wait_idle(1, 1100, cnt);

        // Reset in the middle of a wipe.
        next();
        clear_req = 1'b1; pen_req = 1'b1; pen_addr = 10'd20; pen_data = 1'b1;
        push_clr();
        #1;
        chk("clear_req_pen_first", 32'(pen_ack0), 32'd1);
        chk("clear_req_pen_addr", 32'(ram_addr0), 32'd20);
        next(); clear_req = 1'b0; pen_req = 1'b0; #1;
        chk("clear_req_busy", 32'(busy0), 32'd1);
        chk("clear_req_addr0", 32'(ram_addr0), 32'd0);
        n = 0;
        while (ram_addr0 != 10'd300 && n < 400) begin
            next(); #1; n++;
        end
        chk("clear_reached_300", 32'(ram_addr0), 32'd300);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_busy1", 32'(busy1), 32'd0);
        chk("mid_rst_ram_en", 32'(ram_en0), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we0), 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr0), 32'd0);
        chk("mid_rst_char_out", 32'(char_out0), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt0), 32'd0);
        clr_q.delete();
        next(); rst = 1'b0; #1;
        chk("post_rst_idle", 32'(busy0), 32'd0);
        next(); pen_req = 1'b1; pen_addr = 10'd12; pen_data = 1'b1; #1;
        chk("post_rst_pen_ack", 32'(pen_ack0), 32'd1);
        chk("post_rst_ram_we", 32'(ram_we0), 32'd1);
        chk("post_rst_ram_addr", 32'(ram_addr0), 32'd12);
        chk("post_rst_ram_wdata", 32'(ram_wdata0), 32'd1);
        next(); pen_req = 1'b0; #1;
        next(); next(); #1;

        chk("char_queue_drained", 32'(char_q.size()), 32'd0);
        chk("clr_queue_drained", 32'(clr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
